// File: rtl/clk_gate_idle_tracker.sv
// Upstream idle tracker for the source clock gate: counts outstanding transactions,
// drives dst_idle/src_req, stalls requests while the gated clock wakes up.
module clk_gate_idle_tracker #(
  parameter  int MAX_OUT  = 8,
  parameter  int WAKE_CYC = 2,
  localparam int CW       = $clog2(MAX_OUT + 1)
) (
  input  logic          reset_n,
  input  logic          clk_in,
  input  logic [3:0]    cfg_idle_dly,
  input  logic          req_vld,
  input  logic          req_ack,
  input  logic          dst_busy_in,
  input  logic          clk_enb,
  output logic          req_stall,
  output logic          src_req,
  output logic          dst_idle,
  output logic [CW-1:0] out_cnt,
  output logic          err_unf
);

  localparam int WW = (WAKE_CYC < 1) ? 1 : $clog2(WAKE_CYC + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(MAX_OUT);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [WW-1:0] WAKE_TGT = WW'(WAKE_CYC);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAKE   = 2'd1,
    ST_ACTIVE = 2'd2,
    ST_DRAIN  = 2'd3
  } state_t;

  state_t        state_r, state_nxt_s;
  logic [CW-1:0] out_cnt_r, cnt_nxt_s;
  logic [WW-1:0] wake_cnt_r, wake_nxt_s;
  logic [3:0]    dly_cnt_r, dly_nxt_s;
  logic          err_unf_r, err_nxt_s;
  logic          req_stall_r, stall_nxt_s;
  logic          src_req_r, src_nxt_s;
  logic          dst_idle_r, idle_nxt_s;
  logic          accept_s, drain_ok_s;

  assign accept_s = req_vld & ~req_stall_r;

  // Outstanding count update; an ack with nothing outstanding flags underflow instead.
  always_comb begin
    cnt_nxt_s = out_cnt_r;
    err_nxt_s = err_unf_r;
    if (accept_s && !req_ack) begin
      if (out_cnt_r != CNT_MAX) begin
        cnt_nxt_s = out_cnt_r + CW'(1);
      end else begin
        cnt_nxt_s = out_cnt_r;
      end
    end else if (req_ack && !accept_s) begin
      if (out_cnt_r == CNT_ZERO) begin
        err_nxt_s = 1'b1;
      end else begin
        cnt_nxt_s = out_cnt_r - CW'(1);
      end
    end else begin
      cnt_nxt_s = out_cnt_r;
    end
  end

  assign drain_ok_s = (cnt_nxt_s == CNT_ZERO) & ~dst_busy_in & ~req_vld;

  // Next-state logic for the idle/wake FSM and its counters.
  always_comb begin
    state_nxt_s = state_r;
    wake_nxt_s  = wake_cnt_r;
    dly_nxt_s   = dly_cnt_r;
    case (state_r)
      ST_IDLE: begin
        wake_nxt_s = {WW{1'b0}};
        if (req_vld) begin
          state_nxt_s = ST_WAKE;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_WAKE: begin
        // Only an unbroken run of enabled cycles counts as a stable clock.
        if (clk_enb) begin
          if (wake_cnt_r + WW'(1) >= WAKE_TGT) begin
            state_nxt_s = ST_ACTIVE;
            wake_nxt_s  = {WW{1'b0}};
          end else begin
            wake_nxt_s  = wake_cnt_r + WW'(1);
          end
        end else begin
          wake_nxt_s = {WW{1'b0}};
        end
      end
      ST_ACTIVE: begin
        if (drain_ok_s) begin
          state_nxt_s = ST_DRAIN;
          dly_nxt_s   = cfg_idle_dly;
        end else begin
          state_nxt_s = ST_ACTIVE;
        end
      end
      ST_DRAIN: begin
        if (!drain_ok_s) begin
          state_nxt_s = ST_ACTIVE;
        end else if (dly_cnt_r == 4'd0) begin
          state_nxt_s = ST_IDLE;
        end else begin
          dly_nxt_s   = dly_cnt_r - 4'd1;
        end
      end
      default: begin
        state_nxt_s = ST_ACTIVE;
        wake_nxt_s  = {WW{1'b0}};
        dly_nxt_s   = 4'd0;
      end
    endcase
  end

  // Output decode from the upcoming state so the outputs come straight from flops.
  always_comb begin
    stall_nxt_s = 1'b1;
    src_nxt_s   = 1'b0;
    idle_nxt_s  = 1'b0;
    case (state_nxt_s)
      ST_IDLE: begin
        stall_nxt_s = 1'b1;
        src_nxt_s   = 1'b0;
        idle_nxt_s  = 1'b1;
      end
      ST_WAKE: begin
        stall_nxt_s = 1'b1;
        src_nxt_s   = 1'b1;
        idle_nxt_s  = 1'b0;
      end
      ST_ACTIVE: begin
        stall_nxt_s = (cnt_nxt_s == CNT_MAX);
        src_nxt_s   = req_vld;
        idle_nxt_s  = 1'b0;
      end
      ST_DRAIN: begin
        stall_nxt_s = 1'b0;
        src_nxt_s   = 1'b0;
        idle_nxt_s  = 1'b1;
      end
      default: begin
        stall_nxt_s = 1'b1;
        src_nxt_s   = 1'b0;
        idle_nxt_s  = 1'b0;
      end
    endcase
  end

  // State, counter and output registers.
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= ST_ACTIVE;
      out_cnt_r   <= CNT_ZERO;
      wake_cnt_r  <= {WW{1'b0}};
      dly_cnt_r   <= 4'd0;
      err_unf_r   <= 1'b0;
      req_stall_r <= 1'b0;
      src_req_r   <= 1'b0;
      dst_idle_r  <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      out_cnt_r   <= cnt_nxt_s;
      wake_cnt_r  <= wake_nxt_s;
      dly_cnt_r   <= dly_nxt_s;
      err_unf_r   <= err_nxt_s;
      req_stall_r <= stall_nxt_s;
      src_req_r   <= src_nxt_s;
      dst_idle_r  <= idle_nxt_s;
    end
  end

  assign req_stall = req_stall_r;
  assign src_req   = src_req_r;
  assign dst_idle  = dst_idle_r;
  assign out_cnt   = out_cnt_r;
  assign err_unf   = err_unf_r;

endmodule

// File: tb/tb_clk_gate_idle_tracker.sv
// Directed bench for clk_gate_idle_tracker: a vector table walked from reset,
// followed by hand sequences for reset during WAKE, force-gate and no-gate wake-up.
module tb_clk_gate_idle_tracker;

  logic       clk_in = 1'b0;
  logic       reset_n;
  logic [3:0] cfg_idle_dly;
  logic       req_vld, req_ack, dst_busy_in, clk_enb;
  logic       req_stall, src_req, dst_idle, err_unf;
  logic [3:0] out_cnt;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic       vld, ack, busy, enb;
    logic [3:0] cfg;
    logic [3:0] cnt;
    logic       stall, src, idle, err;
  } vec_t;

  vec_t tbl[$];

  clk_gate_idle_tracker #(.MAX_OUT(8), .WAKE_CYC(2)) dut (
    .reset_n(reset_n), .clk_in(clk_in), .cfg_idle_dly(cfg_idle_dly),
    .req_vld(req_vld), .req_ack(req_ack), .dst_busy_in(dst_busy_in),
    .clk_enb(clk_enb), .req_stall(req_stall), .src_req(src_req),
    .dst_idle(dst_idle), .out_cnt(out_cnt), .err_unf(err_unf)
  );

  always #5 clk_in = ~clk_in;

  function automatic vec_t mk(input logic vld, ack, busy, enb, input logic [3:0] cfg,
                              input logic [3:0] cnt, input logic stall, src, idle, err);
    vec_t r;
    r.vld = vld; r.ack = ack; r.busy = busy; r.enb = enb; r.cfg = cfg;
    r.cnt = cnt; r.stall = stall; r.src = src; r.idle = idle; r.err = err;
    return r;
  endfunction

  task automatic drive(input logic vld, ack, busy, enb, input logic [3:0] cfg);
    req_vld = vld; req_ack = ack; dst_busy_in = busy; clk_enb = enb; cfg_idle_dly = cfg;
  endtask

  task automatic check_out(input string name, input logic [3:0] cnt,
                           input logic stall, src, idle, err);
    n_cmp++;
    if ({out_cnt, req_stall, src_req, dst_idle, err_unf} !== {cnt, stall, src, idle, err}) begin
      n_err++;
      $display("FAIL %s: got cnt=%0d stall=%b src=%b idle=%b err=%b, expected cnt=%0d stall=%b src=%b idle=%b err=%b",
               name, out_cnt, req_stall, src_req, dst_idle, err_unf, cnt, stall, src, idle, err);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  initial begin
    // Reset release with cfg 3: one ACTIVE cycle, four DRAIN cycles, then IDLE.
    for (int i = 0; i < 4; i++) tbl.push_back(mk(0,0,0,0,4'd3, 4'd0,0,0,1,0));
    tbl.push_back(mk(0,0,0,0,4'd3, 4'd0,1,0,1,0));
    tbl.push_back(mk(0,0,0,0,4'd3, 4'd0,1,0,1,0));
    // Wake from IDLE: clk_enb rises two cycles after the request.
    tbl.push_back(mk(1,0,0,0,4'd2, 4'd0,1,1,0,0));
    tbl.push_back(mk(1,0,0,0,4'd2, 4'd0,1,1,0,0));
    tbl.push_back(mk(1,0,0,1,4'd2, 4'd0,1,1,0,0));
    tbl.push_back(mk(1,0,0,1,4'd2, 4'd0,0,1,0,0));
    // Eight back-to-back accepts fill the counter and raise the stall.
    for (int k = 1; k <= 8; k++) tbl.push_back(mk(1,0,0,1,4'd2, 4'(k),(k == 8),1,0,0));
    tbl.push_back(mk(1,0,0,1,4'd2, 4'd8,1,1,0,0));
    tbl.push_back(mk(0,1,0,1,4'd2, 4'd7,0,0,0,0));
    for (int k = 6; k >= 3; k--) tbl.push_back(mk(0,1,0,1,4'd2, 4'(k),0,0,0,0));
    // Accept and ack together at 3 leaves the count unchanged.
    tbl.push_back(mk(1,1,0,1,4'd2, 4'd3,0,1,0,0));
    tbl.push_back(mk(0,1,0,1,4'd2, 4'd2,0,0,0,0));
    tbl.push_back(mk(0,1,0,1,4'd2, 4'd1,0,0,0,0));
    tbl.push_back(mk(0,1,0,1,4'd2, 4'd0,0,0,1,0));
    // Request in DRAIN is taken with no stall and leaves idle at once.
    tbl.push_back(mk(1,0,0,1,4'd2, 4'd1,0,1,0,0));
    tbl.push_back(mk(0,1,0,1,4'd2, 4'd0,0,0,1,0));
    // Ack at zero: sticky underflow.
    tbl.push_back(mk(0,1,0,1,4'd2, 4'd0,0,0,1,1));
    tbl.push_back(mk(0,0,1,1,4'd2, 4'd0,0,0,0,1));
    tbl.push_back(mk(0,0,1,1,4'd2, 4'd0,0,0,0,1));
    tbl.push_back(mk(0,0,0,1,4'd0, 4'd0,0,0,1,1));
    tbl.push_back(mk(0,0,0,1,4'd0, 4'd0,1,0,1,1));
    tbl.push_back(mk(0,1,0,1,4'd0, 4'd0,1,0,1,1));
    // WAKE with clk_enb 1,0,1,1: only the final pair of highs completes the wake.
    tbl.push_back(mk(1,0,0,0,4'd0, 4'd0,1,1,0,1));
    tbl.push_back(mk(1,0,0,1,4'd0, 4'd0,1,1,0,1));
    tbl.push_back(mk(1,0,0,0,4'd0, 4'd0,1,1,0,1));
    tbl.push_back(mk(1,0,0,1,4'd0, 4'd0,1,1,0,1));
    tbl.push_back(mk(1,0,0,1,4'd0, 4'd0,0,1,0,1));

    reset_n = 1'b0;
    drive(0,0,0,0,4'd3);
    #12;
    check_out("reset", 4'd0, 0, 0, 0, 0);
    tick();
    reset_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].vld, tbl[i].ack, tbl[i].busy, tbl[i].enb, tbl[i].cfg);
      tick();
      check_out($sformatf("row%0d", i), tbl[i].cnt, tbl[i].stall, tbl[i].src, tbl[i].idle, tbl[i].err);
    end

    // Back to IDLE, into WAKE, then reset asynchronously mid-WAKE.
    drive(0,0,0,0,4'd0);
    tick(); check_out("seq_drain", 4'd0, 0, 0, 1, 1);
    tick(); check_out("seq_idle", 4'd0, 1, 0, 1, 1);
    drive(1,0,0,0,4'd0);
    tick(); check_out("seq_wake", 4'd0, 1, 1, 0, 1);
    drive(1,0,0,1,4'd0);
    tick(); check_out("seq_wake1", 4'd0, 1, 1, 0, 1);
    #2 reset_n = 1'b0;
    #1 check_out("mid_wake_reset", 4'd0, 0, 0, 0, 0);
    tick(); check_out("reset_held", 4'd0, 0, 0, 0, 0);
    reset_n = 1'b1;
    drive(0,0,0,0,4'd0);
    tick(); check_out("post_rst_drain", 4'd0, 0, 0, 1, 0);
    tick(); check_out("post_rst_idle", 4'd0, 1, 0, 1, 0);

    // Force-gate: clk_enb never rises, the block must hold in WAKE with the stall up.
    drive(1,0,0,0,4'd0);
    for (int c = 0; c < 12; c++) begin
      tick();
      check_out($sformatf("force_gate%0d", c), 4'd0, 1, 1, 0, 0);
    end

    // No-gate: clk_enb high throughout, WAKE lasts exactly two cycles.
    drive(1,0,0,1,4'd0);
    tick(); check_out("nogate_wake1", 4'd0, 1, 1, 0, 0);
    tick(); check_out("nogate_active", 4'd0, 0, 1, 0, 0);
    tick(); check_out("nogate_accept", 4'd1, 0, 1, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
